// File: rtl/ov5640_sccb_master.sv
// SCCB write master for the OV5640: sends {0x78, reg_hi, reg_lo, value} per cfg_start
// and pulses cfg_end when the bus is released again (after STOP or an early NACK STOP).
module ov5640_sccb_master #(
    parameter int         SYS_CLK_FREQ = 50_000_000,
    parameter int         SCL_FREQ     = 250_000,
    parameter logic [6:0] DEVICE_ADDR  = 7'h3C
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cfg_start,
    input  logic [23:0] cfg_data,
    output logic        cfg_end,
    output logic        ack_err,
    output logic        busy,
    output logic        sccb_scl,
    output logic        sccb_sda_oe,
    input  logic        sccb_sda_i
);

    localparam int QCNT_RAW = SYS_CLK_FREQ / (SCL_FREQ * 4);
    localparam int QCNT     = (QCNT_RAW < 2) ? 2 : QCNT_RAW;
    localparam int CNT_W    = $clog2(QCNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QCNT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_BYTE  = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [1:0]       byte_q, byte_d;
    logic [2:0]       bit_q, bit_d;
    logic [23:0]      sr_q, sr_d;
    logic             nack_q, nack_d;
    logic             ack_err_q, ack_err_d;
    logic             busy_q, busy_d;
    logic             cfg_end_q, cfg_end_d;
    logic             scl_q, scl_d;
    logic             sda_oe_q, sda_oe_d;
    logic             tick;
    logic [7:0]       cur_byte_d;

    // Pin levels for a given phase; outputs are registered from the next-state values
    // so SCL/SDA come straight off flops and cannot glitch.
    function automatic logic [1:0] pin_decode(input logic [2:0] st, input logic [1:0] qt,
                                              input logic tx_bit);
        logic scl;
        logic oe;
        scl = 1'b1;
        oe  = 1'b0;
        case (st)
            S_START: begin
                scl = (qt != 2'd3);
                oe  = qt[1];
            end
            S_BYTE: begin
                scl = (qt == 2'd1) || (qt == 2'd2);
                oe  = ~tx_bit;
            end
            S_ACK: begin
                scl = (qt == 2'd1) || (qt == 2'd2);
                oe  = 1'b0;
            end
            S_STOP: begin
                scl = (qt != 2'd0);
                oe  = ~qt[1];
            end
            default: ;
        endcase
        return {scl, oe};
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qtr_d     = qtr_q;
        byte_d    = byte_q;
        bit_d     = bit_q;
        sr_d      = sr_q;
        nack_d    = nack_q;
        ack_err_d = ack_err_q;
        busy_d    = busy_q;
        cfg_end_d = 1'b0;
        tick      = (cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                qtr_d   = '0;
                if (cfg_start) begin
                    state_d   = S_START;
                    sr_d      = cfg_data;
                    ack_err_d = 1'b0;
                    nack_d    = 1'b0;
                    busy_d    = 1'b1;
                    byte_d    = 2'd0;
                    bit_d     = 3'd7;
                end
            end
            default: begin
                cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                end
                // Acknowledge bit is sampled once, mid-way through the high SCL phase.
                if (state_q == S_ACK && qtr_q == 2'd2 && cnt_q == '0) begin
                    nack_d = sccb_sda_i;
                    if (sccb_sda_i) begin
                        ack_err_d = 1'b1;
                    end
                end
                if (tick && qtr_q == 2'd3) begin
                    case (state_q)
                        S_START: begin
                            state_d = S_BYTE;
                            bit_d   = 3'd7;
                        end
                        S_BYTE: begin
                            if (bit_q == 3'd0) begin
                                state_d = S_ACK;
                            end else begin
                                bit_d = bit_q - 3'd1;
                            end
                        end
                        S_ACK: begin
                            if (nack_q || byte_q == 2'd3) begin
                                state_d = S_STOP;
                            end else begin
                                state_d = S_BYTE;
                                byte_d  = byte_q + 2'd1;
                                bit_d   = 3'd7;
                                if (byte_q != 2'd0) begin
                                    sr_d = {sr_q[15:0], 8'h00};
                                end
                            end
                        end
                        S_STOP: begin
                            state_d   = S_DONE;
                            cfg_end_d = 1'b1;
                            busy_d    = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        endcase

        cur_byte_d = (byte_d == 2'd0) ? {DEVICE_ADDR, 1'b0} : sr_d[23:16];
        {scl_d, sda_oe_d} = pin_decode(state_d, qtr_d, cur_byte_d[bit_d]);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            qtr_q     <= 2'd0;
            byte_q    <= 2'd0;
            bit_q     <= 3'd7;
            nack_q    <= 1'b0;
            ack_err_q <= 1'b0;
            busy_q    <= 1'b0;
            cfg_end_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            qtr_q     <= qtr_d;
            byte_q    <= byte_d;
            bit_q     <= bit_d;
            nack_q    <= nack_d;
            ack_err_q <= ack_err_d;
            busy_q    <= busy_d;
            cfg_end_q <= cfg_end_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    // Payload register carries data only; control state alone decides when it is used.
    always_ff @(posedge sys_clk) begin
        sr_q <= sr_d;
    end

    assign cfg_end     = cfg_end_q;
    assign ack_err     = ack_err_q;
    assign busy        = busy_q;
    assign sccb_scl    = scl_q;
    assign sccb_sda_oe = sda_oe_q;

endmodule

// File: doc/ov5640_sccb_master.md
Name: ov5640_sccb_master

Overview:
- SCCB (I2C-compatible) write master that sits between the OV5640 register-table sequencer and the camera's SIOC/SIOD pins.
- Accepts one `{16-bit reg addr, 8-bit value}` word per `cfg_start` pulse.
- Serialises it as a 4-byte SCCB write: device addr+W, addr hi, addr lo, data.
- Pulses `cfg_end` on completion so the sequencer can advance to the next table entry.

Parameters:
- SYS_CLK_FREQ, 50_000_000: sys_clk frequency in Hz.
- SCL_FREQ, 250_000: target SCL frequency in Hz.
- DEVICE_ADDR, 7'h3C: 7-bit SCCB slave address; the transmitted first byte is {DEVICE_ADDR, 1'b0} = 8'h78.
- QCNT, SYS_CLK_FREQ/(SCL_FREQ*4): sys_clk cycles per SCL quarter-period (derived, min 2).

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  single-cycle request to write cfg_data.
- cfg_data  in  24  [23:8] register address, [7:0] register value.
- cfg_end  out  1  single-cycle pulse, transaction finished (success or NACK).
- ack_err  out  1  1 = a NACK was received in the last transaction; valid with cfg_end.
- busy  out  1  transaction in progress.
- sccb_scl  out  1  SCL, push-pull.
- sccb_sda_oe  out  1  1 = drive SIOD low, 0 = release (open-drain; pad pull-up supplies high).
- sccb_sda_i  in  1  SIOD pad input (already synchronised by the pad wrapper).

Behaviour:
- Reset values:
  - cfg_end = 0, ack_err = 0, busy = 0.
  - sccb_scl = 1, sccb_sda_oe = 0.
  - FSM = IDLE, divider = 0.
- Reset mid-transaction: on the next edge, all outputs return to the reset values with no STOP generated. cfg_end is not pulsed.
- Acceptance:
  - cfg_start is sampled only in IDLE.
  - On acceptance, cfg_data is latched into a 24-bit shift register, ack_err clears, and busy = 1 from the next cycle.
  - cfg_start while busy is ignored. It is neither queued nor does it cause an error.
- Divider:
  - Counts 0..QCNT-1 and restarts at 0 on acceptance.
  - A quarter tick occurs when the count reaches QCNT-1.
  - Every phase below lasts exactly one quarter (QCNT cycles).
- FSM states: IDLE, START, BYTE, ACK, STOP, DONE. A 2-bit byte index (0..3) and a 3-bit bit index (7..0) are kept.
- START, quarters q0..q3:
  - SCL = 1,1,1,0.
  - SDA released, released, low, low.
- BYTE, each bit MSB first, 4 quarters:
  - q0: SCL = 0, SDA = bit (oe = ~bit).
  - q1, q2: SCL = 1.
  - q3: SCL = 0.
  - After bit 0, go to ACK.
- Byte order: 8'h78, cfg_data[23:16], cfg_data[15:8], cfg_data[7:0].
- ACK, 4 quarters:
  - SDA released; SCL = 0,1,1,0.
  - sccb_sda_i is sampled on the first cycle of q2; 1 = NACK.
  - If ACK and byte index < 3: next byte. If ACK and byte index = 3: STOP.
  - If NACK: set ack_err = 1 and go to STOP immediately, skipping the remaining bytes.
- STOP, quarters q0..q3:
  - SCL = 0,1,1,1.
  - SDA low, low, released, released.
- DONE: single cycle.
  - cfg_end = 1 and busy falls to 0 on the same edge.
  - Return to IDLE.
  - A cfg_start coinciding with the cfg_end cycle is accepted; the sequencer's back-to-back pulse is legal.
- Latency for a full successful write:
  - 152 quarters = START 4 + 4 × 36 + STOP 4.
  - cfg_end is asserted exactly 152*QCNT+1 cycles after the cfg_start cycle.
- Latency for a NACK on byte n (0-based): (4 + 36*(n+1) + 4)*QCNT + 1 cycles.
- ack_err holds its value until the next accepted cfg_start.
- SCL/SDA change only at quarter boundaries; SDA never changes while SCL = 1, except for START and STOP.

Test Plan:
- Reset then idle (SYS_CLK_FREQ=4_000_000, SCL_FREQ=250_000, QCNT=4) -> scl=1, sda_oe=0, busy=0, cfg_end never pulses.
- cfg_start with cfg_data=24'h300882, slave model always ACKs:
  - Bus monitor decodes START, 78/30/08/82, STOP.
  - cfg_end pulses at cycle +609; ack_err=0.
- Slave NACKs byte 1 (8'h30) -> STOP follows immediately after that ACK slot; cfg_end at (4+72+4)*4+1 = 321 cycles; ack_err=1; no further bytes seen.
- cfg_start pulsed repeatedly while busy -> ignored; exactly one transaction and one cfg_end.
- Sequencer-style back-to-back: cfg_start in the same cycle as cfg_end with 24'h300842 -> second transaction starts with no gap cycle; both decoded correctly.
- sys_rst asserted mid-byte 2 -> next edge scl=1, sda_oe=0, busy=0, no cfg_end; a subsequent cfg_start completes normally.
